snake_body_engine: RTL and testbench

//  Parametrised snake movement/render engine: variable-length body, growth on food,

---
 rtl/snake_body_engine.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// snake_body_engine
//   Snake movement and render engine. Holds a variable-length body, advances the
//   head one cell per tick, grows on food, detects wall/self collisions (or wraps
//   at the screen edge) and sequences the pixel writes for a vga_adapter.
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   start                pulse: reload the body and run (honoured in IDLE/OVER)
//   tick                 step strobe, honoured only in RUN
//   dir_valid, dir_in    direction request (0 left, 1 right, 2 up, 3 down)
//   food_x, food_y       current food cell
//   food_req             pulse in the step that eats the food
//   length               current body length
//   game_over            high in OVER
//   busy                 high while a step is computed or rendered
//   plot, x_out, y_out   pixel write strobe and coordinates
//   colour               3'b010 body, 3'b000 erase
module snake_body_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 6,
    parameter int SEG      = 4,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int X_MAX    = 160,
    parameter int Y_MAX    = 120,
    parameter int START_X  = 80,
    parameter int START_Y  = 60,
    parameter int WRAP     = 0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          tick,
    input  logic          dir_valid,
    input  logic [1:0]    dir_in,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    output logic          food_req,
    output logic [6:0]    length,
    output logic          game_over,
    output logic          busy,
    output logic          plot,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [2:0]    colour
);

    localparam int LG = $clog2(SEG);
    localparam int PW = 2 * LG;
    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_DRAW, S_RUN, S_MOVE, S_DRAW_HEAD, S_ERASE_TAIL, S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    dir_q, dir_d, pend_q, pend_d;
    logic [PW-1:0] p_q, p_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [6:0]    length_q, length_d;
    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    logic [XW-1:0] tail_x_q, tail_x_d;
    logic [YW-1:0] tail_y_q, tail_y_d;
    logic          erase_q, erase_d;

    logic [XW-1:0] nx_s;
    logic [YW-1:0] ny_s;
    logic          edge_s, grow_s, self_hit_s, fatal_s;
    logic [IW-1:0] tail_idx_s;
    logic          last_pix_s;

    // Candidate head position for the pending direction, with edge and collision detection.
    always_comb begin
        nx_s       = seg_x_q[0];
        ny_s       = seg_y_q[0];
        edge_s     = 1'b0;
        self_hit_s = 1'b0;
        tail_idx_s = IW'(length_q - 7'd1);
        // Edge tests are done before the add/subtract so an underflow is never truncated away.
        case (pend_q)
            2'd0: begin
                if (seg_x_q[0] < XW'(SEG)) begin
                    edge_s = 1'b1;
                    nx_s   = XW'(X_MAX - SEG);
                end else begin
                    nx_s = seg_x_q[0] - XW'(SEG);
                end
            end
            2'd1: begin
                if (({1'b0, seg_x_q[0]} + (XW+1)'(SEG)) > (XW+1)'(X_MAX - SEG)) begin
                    edge_s = 1'b1;
                    nx_s   = {XW{1'b0}};
                end else begin
                    nx_s = seg_x_q[0] + XW'(SEG);
                end
            end
            2'd2: begin
                if (seg_y_q[0] < YW'(SEG)) begin
                    edge_s = 1'b1;
                    ny_s   = YW'(Y_MAX - SEG);
                end else begin
                    ny_s = seg_y_q[0] - YW'(SEG);
                end
            end
            2'd3: begin
                if (({1'b0, seg_y_q[0]} + (YW+1)'(SEG)) > (YW+1)'(Y_MAX - SEG)) begin
                    edge_s = 1'b1;
                    ny_s   = {YW{1'b0}};
                end else begin
                    ny_s = seg_y_q[0] + YW'(SEG);
                end
            end
            default: begin
                edge_s = 1'b0;
            end
        endcase
        grow_s = (nx_s == food_x) && (ny_s == food_y);
        // The tail cell is free to enter only when it moves away this step (no growth).
        for (int i = 0; i < MAX_LEN; i++) begin
            self_hit_s = self_hit_s | ((7'(i) < length_q) &&
                         (grow_s || (7'(i) != (length_q - 7'd1))) &&
                         (seg_x_q[i] == nx_s) && (seg_y_q[i] == ny_s));
        end
        fatal_s = (edge_s && (WRAP == 0)) || self_hit_s;
    end

    assign last_pix_s = (p_q == {PW{1'b1}});

    // Next-state, body update and direction filtering.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        p_d      = p_q;
        idx_d    = idx_q;
        length_d = length_q;
        seg_x_d  = seg_x_q;
        seg_y_d  = seg_y_q;
        tail_x_d = tail_x_q;
        tail_y_d = tail_y_q;
        erase_d  = erase_q;
        // Reversal is judged against the direction actually travelled, not the pending one.
        if (dir_valid && (dir_in != (dir_q ^ 2'b01))) begin
            pend_d = dir_in;
        end else begin
            pend_d = pend_q;
        end
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x_d[i] = XW'(START_X - i * SEG);
                        seg_y_d[i] = YW'(START_Y);
                    end
                    length_d = 7'(INIT_LEN);
                    dir_d    = 2'd1;
                    pend_d   = 2'd1;
                    p_d      = {PW{1'b0}};
                    idx_d    = {IW{1'b0}};
                    erase_d  = 1'b0;
                    state_d  = S_INIT_DRAW;
                end else begin
                    state_d = state_q;
                end
            end
            S_INIT_DRAW: begin
                p_d = p_q + PW'(1);
                if (last_pix_s) begin
                    if (idx_q == IW'(INIT_LEN - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_RUN: begin
                if (tick) begin
                    state_d = S_MOVE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MOVE: begin
                dir_d = pend_q;
                if (fatal_s) begin
                    state_d = S_OVER;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = nx_s;
                    seg_y_d[0] = ny_s;
                    tail_x_d   = seg_x_q[tail_idx_s];
                    tail_y_d   = seg_y_q[tail_idx_s];
                    // At full length a meal still drops the tail; a head landing on the old tail keeps it lit.
                    erase_d = (!grow_s || (length_q == 7'(MAX_LEN))) &&
                              !((nx_s == seg_x_q[tail_idx_s]) && (ny_s == seg_y_q[tail_idx_s]));
                    if (grow_s && (length_q < 7'(MAX_LEN))) begin
                        length_d = length_q + 7'd1;
                    end else begin
                        length_d = length_q;
                    end
                    p_d     = {PW{1'b0}};
                    state_d = S_DRAW_HEAD;
                end
            end
            S_DRAW_HEAD: begin
                p_d = p_q + PW'(1);
                if (last_pix_s) begin
                    state_d = erase_q ? S_ERASE_TAIL : S_RUN;
                end else begin
                    state_d = S_DRAW_HEAD;
                end
            end
            S_ERASE_TAIL: begin
                p_d = p_q + PW'(1);
                if (last_pix_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_ERASE_TAIL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and body registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            dir_q    <= 2'd1;
            pend_q   <= 2'd1;
            p_q      <= {PW{1'b0}};
            idx_q    <= {IW{1'b0}};
            length_q <= 7'd0;
            tail_x_q <= {XW{1'b0}};
            tail_y_q <= {YW{1'b0}};
            erase_q  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= XW'(START_X - i * SEG);
                seg_y_q[i] <= YW'(START_Y);
            end
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            p_q      <= p_d;
            idx_q    <= idx_d;
            length_q <= length_d;
            tail_x_q <= tail_x_d;
            tail_y_q <= tail_y_d;
            erase_q  <= erase_d;
            seg_x_q  <= seg_x_d;
            seg_y_q  <= seg_y_d;
        end
    end

    // Output decode from the state register and pixel counter.
    always_comb begin
        plot      = 1'b0;
        busy      = 1'b0;
        game_over = 1'b0;
        food_req  = 1'b0;
        colour    = 3'b000;
        x_out     = {XW{1'b0}};
        y_out     = {YW{1'b0}};
        length    = length_q;
        case (state_q)
            S_INIT_DRAW: begin
                plot   = 1'b1;
                colour = 3'b010;
                x_out  = seg_x_q[idx_q] + XW'(p_q[LG-1:0]);
                y_out  = seg_y_q[idx_q] + YW'(p_q[PW-1:LG]);
            end
            S_MOVE: begin
                busy     = 1'b1;
                food_req = grow_s && !fatal_s;
            end
            S_DRAW_HEAD: begin
                busy   = 1'b1;
                plot   = 1'b1;
                colour = 3'b010;
                x_out  = seg_x_q[0] + XW'(p_q[LG-1:0]);
                y_out  = seg_y_q[0] + YW'(p_q[PW-1:LG]);
            end
            S_ERASE_TAIL: begin
                busy   = 1'b1;
                plot   = 1'b1;
                colour = 3'b000;
                x_out  = tail_x_q + XW'(p_q[LG-1:0]);
                y_out  = tail_y_q + YW'(p_q[PW-1:LG]);
            end
            S_OVER: begin
                game_over = 1'b1;
            end
            default: begin
                plot = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed testbench for snake_body_engine: a WRAP=0 instance is checked in
// every scenario; a WRAP=1 instance receives the same stimulus and is checked
// at the right-hand screen edge.
module tb_snake_body_engine;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic [7:0] food_x = 8'd0;
    logic [6:0] food_y = 7'd0;

    logic       food_req, game_over, busy, plot;
    logic [6:0] length;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       w_food_req, w_game_over, w_busy, w_plot;
    logic [6:0] w_length;
    logic [7:0] w_x_out;
    logic [6:0] w_y_out;
    logic [2:0] w_colour;

    int checks = 0;
    int errors = 0;

    int cap_fr, cap_nb, cap_nh, cap_ne;
    int cap_hx0, cap_hy0, cap_hxl, cap_hyl, cap_ex0, cap_ey0, cap_exl, cap_eyl;

    snake_body_engine #(.WRAP(0)) dut (
        .clk(clk), .resetn(resetn), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_in(dir_in), .food_x(food_x), .food_y(food_y),
        .food_req(food_req), .length(length), .game_over(game_over), .busy(busy),
        .plot(plot), .x_out(x_out), .y_out(y_out), .colour(colour)
    );

    snake_body_engine #(.WRAP(1)) dut_w (
        .clk(clk), .resetn(resetn), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_in(dir_in), .food_x(food_x), .food_y(food_y),
        .food_req(w_food_req), .length(w_length), .game_over(w_game_over), .busy(w_busy),
        .plot(w_plot), .x_out(w_x_out), .y_out(w_y_out), .colour(w_colour)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step_clk();
        start = 1'b0;
    endtask

    // Leaves the bench in the MOVE cycle.
    task automatic tick_pulse();
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
    endtask

    task automatic dir_pulse(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_in    = d;
        step_clk();
        dir_valid = 1'b0;
    endtask

    // Records one step from its MOVE cycle until busy drops; optionally pulses tick mid-step.
    task automatic capture(input int tick_at);
        cap_fr = int'(food_req);
        cap_nb = 0; cap_nh = 0; cap_ne = 0;
        cap_hx0 = -1; cap_hy0 = -1; cap_hxl = -1; cap_hyl = -1;
        cap_ex0 = -1; cap_ey0 = -1; cap_exl = -1; cap_eyl = -1;
        for (int c = 0; c < 100; c++) begin
            if (busy !== 1'b1) break;
            cap_nb++;
            if (plot === 1'b1 && colour === 3'b010) begin
                if (cap_nh == 0) begin cap_hx0 = int'(x_out); cap_hy0 = int'(y_out); end
                cap_hxl = int'(x_out); cap_hyl = int'(y_out);
                cap_nh++;
            end else if (plot === 1'b1 && colour === 3'b000) begin
                if (cap_ne == 0) begin cap_ex0 = int'(x_out); cap_ey0 = int'(y_out); end
                cap_exl = int'(x_out); cap_eyl = int'(y_out);
                cap_ne++;
            end
            tick = (c == tick_at);
            step_clk();
        end
        tick = 1'b0;
        checks++;
        if (busy === 1'b1) begin
            errors++;
            $display("FAIL step_timeout busy still %0b after 100 cycles, expected 0", busy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({plot, busy, game_over, food_req, colour} !== 7'd0 || x_out !== 8'd0 || y_out !== 7'd0 || length !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs plot=%0b busy=%0b over=%0b fr=%0b col=%0d x=%0d y=%0d len=%0d, expected all 0",
                     plot, busy, game_over, food_req, colour, x_out, y_out, length);
        end
        step_clk();
        resetn = 1'b1;
        repeat (3) step_clk();
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet plot=%0b busy=%0b, expected 0 0", plot, busy);
        end
    endtask

    task automatic test_init_draw();
        int n = 0, bad = 0, fx = -1, fy = -1, lx = -1, ly = -1;
        start_pulse();
        for (int c = 0; c < 200; c++) begin
            if (plot !== 1'b1) break;
            if (n == 0) begin fx = int'(x_out); fy = int'(y_out); end
            lx = int'(x_out); ly = int'(y_out);
            if (colour !== 3'b010 || busy !== 1'b0) bad++;
            n++;
            step_clk();
        end
        checks++;
        if (n !== 96) begin errors++; $display("FAIL init_count got %0d, expected 96", n); end
        checks++;
        if (fx !== 80 || fy !== 60) begin errors++; $display("FAIL init_first got (%0d,%0d), expected (80,60)", fx, fy); end
        checks++;
        if (lx !== 63 || ly !== 63) begin errors++; $display("FAIL init_last got (%0d,%0d), expected (63,63)", lx, ly); end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL init_colour_busy got %0d bad cycles, expected 0", bad); end
        checks++;
        if (length !== 7'd6 || game_over !== 1'b0) begin
            errors++; $display("FAIL init_length got len=%0d over=%0b, expected 6 0", length, game_over);
        end
    endtask

    task automatic test_step_plain();
        food_x = 8'd0; food_y = 7'd0;
        tick_pulse();
        checks++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            errors++; $display("FAIL move_cycle got busy=%0b plot=%0b, expected 1 0", busy, plot);
        end
        capture(-1);
        checks++;
        if (cap_fr !== 0) begin errors++; $display("FAIL plain_food_req got %0d, expected 0", cap_fr); end
        checks++;
        if (cap_nh !== 16 || cap_hx0 !== 84 || cap_hy0 !== 60 || cap_hxl !== 87 || cap_hyl !== 63) begin
            errors++; $display("FAIL plain_head got n=%0d (%0d,%0d)..(%0d,%0d), expected 16 (84,60)..(87,63)",
                               cap_nh, cap_hx0, cap_hy0, cap_hxl, cap_hyl);
        end
        checks++;
        if (cap_ne !== 16 || cap_ex0 !== 60 || cap_ey0 !== 60 || cap_exl !== 63 || cap_eyl !== 63) begin
            errors++; $display("FAIL plain_erase got n=%0d (%0d,%0d)..(%0d,%0d), expected 16 (60,60)..(63,63)",
                               cap_ne, cap_ex0, cap_ey0, cap_exl, cap_eyl);
        end
        checks++;
        if (length !== 7'd6 || cap_nb !== 33) begin
            errors++; $display("FAIL plain_len_busy got len=%0d busy=%0d, expected 6 33", length, cap_nb);
        end
    endtask

    task automatic test_grow();
        food_x = 8'd88; food_y = 7'd60;
        tick_pulse();
        capture(-1);
        food_x = 8'd0; food_y = 7'd0;
        checks++;
        if (cap_fr !== 1) begin errors++; $display("FAIL grow_food_req got %0d, expected 1", cap_fr); end
        checks++;
        if (length !== 7'd7) begin errors++; $display("FAIL grow_length got %0d, expected 7", length); end
        checks++;
        if (cap_ne !== 0 || cap_nb !== 17 || cap_hx0 !== 88) begin
            errors++; $display("FAIL grow_no_erase got erase=%0d busy=%0d hx=%0d, expected 0 17 88", cap_ne, cap_nb, cap_hx0);
        end
    endtask

    task automatic test_direction();
        dir_pulse(2'd0);
        tick_pulse();
        capture(-1);
        checks++;
        if (cap_hx0 !== 92 || cap_hy0 !== 60 || cap_ex0 !== 64 || cap_ey0 !== 60) begin
            errors++; $display("FAIL reverse_ignored got head (%0d,%0d) tail (%0d,%0d), expected (92,60) (64,60)",
                               cap_hx0, cap_hy0, cap_ex0, cap_ey0);
        end
        dir_pulse(2'd2);
        dir_pulse(2'd3);
        tick_pulse();
        capture(-1);
        checks++;
        if (cap_hx0 !== 92 || cap_hy0 !== 64 || cap_ex0 !== 68 || cap_ey0 !== 60) begin
            errors++; $display("FAIL last_dir_wins got head (%0d,%0d) tail (%0d,%0d), expected (92,64) (68,60)",
                               cap_hx0, cap_hy0, cap_ex0, cap_ey0);
        end
    endtask

    task automatic test_back_to_back();
        int extra = 0;
        tick_pulse();
        capture(3);
        checks++;
        if (cap_hx0 !== 92 || cap_hy0 !== 68 || cap_ex0 !== 72) begin
            errors++; $display("FAIL busy_step got head (%0d,%0d) tail x %0d, expected (92,68) 72", cap_hx0, cap_hy0, cap_ex0);
        end
        for (int c = 0; c < 6; c++) begin
            if (busy === 1'b1) extra++;
            step_clk();
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL busy_tick_dropped got %0d busy cycles, expected 0", extra); end
    endtask

    task automatic test_self_collision();
        int n = 0;
        dir_pulse(2'd0);
        tick_pulse();
        capture(-1);
        dir_pulse(2'd2);
        tick_pulse();
        capture(-1);
        checks++;
        if (cap_hx0 !== 88 || cap_hy0 !== 64 || game_over !== 1'b0) begin
            errors++; $display("FAIL loop_path got head (%0d,%0d) over=%0b, expected (88,64) 0", cap_hx0, cap_hy0, game_over);
        end
        dir_pulse(2'd1);
        tick_pulse();
        step_clk();
        checks++;
        if (game_over !== 1'b1 || plot !== 1'b0 || busy !== 1'b0 || length !== 7'd7) begin
            errors++; $display("FAIL self_hit got over=%0b plot=%0b busy=%0b len=%0d, expected 1 0 0 7",
                               game_over, plot, busy, length);
        end
        tick_pulse();
        for (int c = 0; c < 20; c++) begin
            if (plot === 1'b1 || busy === 1'b1 || game_over !== 1'b1) n++;
            step_clk();
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL over_frozen got %0d active cycles, expected 0", n); end
    endtask

    task automatic test_wrap();
        int lastx = -1;
        start_pulse();
        for (int c = 0; c < 200; c++) begin
            if (plot !== 1'b1) break;
            step_clk();
        end
        for (int k = 0; k < 19; k++) begin
            tick_pulse();
            capture(-1);
            lastx = cap_hx0;
        end
        checks++;
        if (lastx !== 156) begin errors++; $display("FAIL edge_reach got head x %0d, expected 156", lastx); end
        tick_pulse();
        step_clk();
        checks++;
        if (game_over !== 1'b1 || plot !== 1'b0) begin
            errors++; $display("FAIL wall_over got over=%0b plot=%0b, expected 1 0", game_over, plot);
        end
        checks++;
        if (w_game_over !== 1'b0 || w_plot !== 1'b1 || w_x_out !== 8'd0 || w_y_out !== 7'd60 || w_colour !== 3'b010) begin
            errors++; $display("FAIL wrap_head got over=%0b plot=%0b (%0d,%0d) col=%0d, expected 0 1 (0,60) 2",
                               w_game_over, w_plot, w_x_out, w_y_out, w_colour);
        end
    endtask

    task automatic test_reset_mid_draw();
        start_pulse();
        repeat (5) step_clk();
        checks++;
        if (plot !== 1'b1) begin errors++; $display("FAIL redraw_active got plot=%0b, expected 1", plot); end
        resetn = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || length !== 7'd0 || game_over !== 1'b0 || x_out !== 8'd0) begin
            errors++; $display("FAIL async_reset got plot=%0b len=%0d over=%0b x=%0d, expected 0 0 0 0",
                               plot, length, game_over, x_out);
        end
        step_clk();
        resetn = 1'b1;
        step_clk();
        tick_pulse();
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset got busy=%0b plot=%0b, expected 0 0", busy, plot);
        end
        start_pulse();
        checks++;
        if (plot !== 1'b1 || x_out !== 8'd80 || y_out !== 7'd60 || length !== 7'd6) begin
            errors++; $display("FAIL restart_clean got plot=%0b (%0d,%0d) len=%0d, expected 1 (80,60) 6",
                               plot, x_out, y_out, length);
        end
    endtask

    initial begin
        test_reset();
        test_init_draw();
        test_step_plain();
        test_grow();
        test_direction();
        test_back_to_back();
        test_self_collision();
        test_wrap();
        test_reset_mid_draw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
